// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-bus round-robin arbiter.
package reg_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DefNumReq        = 2;
  localparam int DefAddrWidth     = 32;
  localparam int DefDataWidth     = 32;
  localparam int DefTimeoutCycles = 256;

  // Bits needed to hold an index below n; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_sel.sv
// Combinational round-robin picker: the pointer position has top priority,
// and priority falls with increasing index, wrapping at NumReq.
module rr_arb_sel
  import reg_arb_pkg::*;
#(
  parameter int NumReq = DefNumReq,
  parameter int IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  // Scan from the pointer and take the first requester found.
  always_comb begin
    logic found;
    int   cand;
    found = 1'b0;
    cand  = 0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = (int'(ptr_i) + i) % NumReq;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IdxW'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/reg_bus_rr_arbiter.sv
// Shares one downstream register-bus target between NumReq requesters.
// A round-robin winner is captured in IDLE and presented downstream in BUSY;
// an optional watchdog forces an error response on a hung target.
module reg_bus_rr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NumReq        = DefNumReq,
  parameter int AddrWidth     = DefAddrWidth,
  parameter int DataWidth     = DefDataWidth,
  parameter int TimeoutCycles = DefTimeoutCycles
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq-1:0]             req_write_i,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
  input  logic [NumReq*DataWidth/8-1:0] req_wstrb_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic [DataWidth-1:0]          req_rdata_o,
  output logic [NumReq-1:0]             req_error_o,
  output logic                          reg_valid_o,
  output logic                          reg_write_o,
  output logic [AddrWidth-1:0]          reg_addr_o,
  output logic [DataWidth-1:0]          reg_wdata_o,
  output logic [DataWidth/8-1:0]        reg_wstrb_o,
  input  logic                          reg_ready_i,
  input  logic [DataWidth-1:0]          reg_rdata_i,
  input  logic                          reg_error_i,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int IdxW  = idx_width(NumReq);
  localparam int StrbW = DataWidth / 8;
  localparam int CntW  = idx_width(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast =
      CntW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);
  localparam bit WdogOn = (TimeoutCycles != 0);

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   win_q;
  logic              write_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [StrbW-1:0]  wstrb_q;
  logic [CntW-1:0]   cnt_q;

  logic [NumReq-1:0] sel_gnt;
  logic [IdxW-1:0]   sel_idx;
  logic              sel_valid;
  logic              rsp_normal;
  logic              rsp_timeout;

  rr_arb_sel #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_sel (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (sel_gnt),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  // Completion decode and response steering; a coincident ready beats the
  // watchdog, and nothing is answered while reset is being applied.
  always_comb begin
    rsp_normal  = (state_q == BUSY) && reg_ready_i && rst_ni;
    rsp_timeout = WdogOn && (state_q == BUSY) && !reg_ready_i &&
                  (cnt_q == CntLast) && rst_ni;
    ptr_d       = (win_q == IdxW'(NumReq - 1)) ? '0 : win_q + 1'b1;
    req_ready_o = '0;
    req_error_o = '0;
    req_rdata_o = '0;
    timeout_o   = 1'b0;
    if (rsp_normal) begin
      req_ready_o[win_q] = 1'b1;
      req_error_o[win_q] = reg_error_i;
      req_rdata_o        = reg_rdata_i;
    end else if (rsp_timeout) begin
      req_ready_o[win_q] = 1'b1;
      req_error_o[win_q] = 1'b1;
      timeout_o          = 1'b1;
    end
  end

  // Downstream request comes straight from the capture registers.
  always_comb begin
    reg_valid_o = (state_q == BUSY);
    busy_o      = (state_q == BUSY);
    reg_write_o = write_q;
    reg_addr_o  = addr_q;
    reg_wdata_o = wdata_q;
    reg_wstrb_o = wstrb_q;
  end

  // Arbiter FSM: capture the winner in IDLE, hold it in BUSY until answered.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (sel_valid) begin
            state_q <= BUSY;
            win_q   <= sel_idx;
            write_q <= |(req_write_i & sel_gnt);
            addr_q  <= req_addr_i[int'(sel_idx)*AddrWidth +: AddrWidth];
            wdata_q <= req_wdata_i[int'(sel_idx)*DataWidth +: DataWidth];
            wstrb_q <= req_wstrb_i[int'(sel_idx)*StrbW +: StrbW];
          end
        end
        BUSY: begin
          if (rsp_normal || rsp_timeout) begin
            state_q <= IDLE;
            ptr_q   <= ptr_d;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_rr_arbiter.sv
// Directed, table-driven bench for reg_bus_rr_arbiter with a short watchdog.
module tb_reg_bus_rr_arbiter;

  localparam int NumReq = 2;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int TO     = 8;

  localparam logic [31:0] Addr0  = 32'h0000_0010;
  localparam logic [31:0] Addr1  = 32'h0000_0020;
  localparam logic [31:0] Wdata0 = 32'hDEAD_BEEF;
  localparam logic [31:0] Wdata1 = 32'h0BAD_F00D;

  logic                 clk;
  logic                 rstN;
  logic [NumReq-1:0]    reqValid;
  logic [NumReq-1:0]    reqWrite;
  logic [NumReq*AW-1:0] reqAddr;
  logic [NumReq*DW-1:0] reqWdata;
  logic [NumReq*DW/8-1:0] reqWstrb;
  logic [NumReq-1:0]    reqReady;
  logic [DW-1:0]        reqRdata;
  logic [NumReq-1:0]    reqError;
  logic                 regValid;
  logic                 regWrite;
  logic [AW-1:0]        regAddr;
  logic [DW-1:0]        regWdata;
  logic [DW/8-1:0]      regWstrb;
  logic                 regReady;
  logic [DW-1:0]        regRdata;
  logic                 regError;
  logic                 busy;
  logic                 timeoutPulse;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0]  valid;
    logic        rdy;
    logic        err;
    logic [31:0] rdata;
    logic [1:0]  eReady;
    logic [1:0]  eErr;
    logic [31:0] eRdata;
    logic        eBusy;
    logic        eTo;
    logic [31:0] eAddr;
  } vec_t;

  vec_t vecs[$];

  reg_bus_rr_arbiter #(
    .NumReq        (NumReq),
    .AddrWidth     (AW),
    .DataWidth     (DW),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .req_valid_i (reqValid),
    .req_write_i (reqWrite),
    .req_addr_i  (reqAddr),
    .req_wdata_i (reqWdata),
    .req_wstrb_i (reqWstrb),
    .req_ready_o (reqReady),
    .req_rdata_o (reqRdata),
    .req_error_o (reqError),
    .reg_valid_o (regValid),
    .reg_write_o (regWrite),
    .reg_addr_o  (regAddr),
    .reg_wdata_o (regWdata),
    .reg_wstrb_o (regWstrb),
    .reg_ready_i (regReady),
    .reg_rdata_i (regRdata),
    .reg_error_i (regError),
    .busy_o      (busy),
    .timeout_o   (timeoutPulse)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] valid, input logic rdy,
                              input logic err, input logic [31:0] rdata,
                              input logic [1:0] eReady, input logic [1:0] eErr,
                              input logic [31:0] eRdata, input logic eBusy,
                              input logic eTo, input logic [31:0] eAddr);
    vec_t v;
    v.valid = valid;   v.rdy = rdy;       v.err = err;     v.rdata = rdata;
    v.eReady = eReady; v.eErr = eErr;     v.eRdata = eRdata;
    v.eBusy = eBusy;   v.eTo = eTo;       v.eAddr = eAddr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, let the combinational responses settle, check
  // everything the vector predicts, then advance past the next rising edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    reqValid = v.valid;
    regReady = v.rdy;
    regError = v.err;
    regRdata = v.rdata;
    #2;
    checkOutput({tag, " ready"}, 64'(reqReady), 64'(v.eReady));
    checkOutput({tag, " error"}, 64'(reqError), 64'(v.eErr));
    checkOutput({tag, " rdata"}, 64'(reqRdata), 64'(v.eRdata));
    checkOutput({tag, " busy"}, 64'(busy), 64'(v.eBusy));
    checkOutput({tag, " reg_valid"}, 64'(regValid), 64'(v.eBusy));
    checkOutput({tag, " timeout"}, 64'(timeoutPulse), 64'(v.eTo));
    if (v.eBusy) begin
      checkOutput({tag, " reg_addr"}, 64'(regAddr), 64'(v.eAddr));
      checkOutput({tag, " reg_wdata"}, 64'(regWdata),
                  64'((v.eAddr == Addr0) ? Wdata0 : Wdata1));
      checkOutput({tag, " reg_write"}, 64'(regWrite),
                  64'((v.eAddr == Addr0) ? 1'b1 : 1'b0));
      checkOutput({tag, " reg_wstrb"}, 64'(regWstrb),
                  64'((v.eAddr == Addr0) ? 4'hF : 4'h0));
    end
    nextCycle();
  endtask

  initial begin
    vec_t v;

    // Requester 0 always writes DEADBEEF to 0x10; requester 1 reads 0x20.
    reqValid = '0;
    reqWrite = 2'b01;
    reqAddr  = {Addr1, Addr0};
    reqWdata = {Wdata1, Wdata0};
    reqWstrb = {4'h0, 4'hF};
    regReady = 1'b0;
    regRdata = '0;
    regError = 1'b0;
    rstN     = 1'b0;

    // Contention from reset: strict alternation 0,1,0,1 with a zero-wait target.
    vecs.push_back(mk(2'b11, 1, 0, 32'h77, 2'b00, 2'b00, 32'h0,  0, 0, 32'h0));
    vecs.push_back(mk(2'b11, 1, 0, 32'h77, 2'b01, 2'b00, 32'h77, 1, 0, Addr0));
    vecs.push_back(mk(2'b11, 1, 0, 32'h77, 2'b00, 2'b00, 32'h0,  0, 0, 32'h0));
    vecs.push_back(mk(2'b11, 1, 0, 32'h77, 2'b10, 2'b00, 32'h77, 1, 0, Addr1));
    vecs.push_back(mk(2'b11, 1, 0, 32'h77, 2'b00, 2'b00, 32'h0,  0, 0, 32'h0));
    vecs.push_back(mk(2'b11, 1, 0, 32'h77, 2'b01, 2'b00, 32'h77, 1, 0, Addr0));
    vecs.push_back(mk(2'b11, 1, 0, 32'h77, 2'b00, 2'b00, 32'h0,  0, 0, 32'h0));
    vecs.push_back(mk(2'b11, 1, 0, 32'h77, 2'b10, 2'b00, 32'h77, 1, 0, Addr1));
    vecs.push_back(mk(2'b00, 0, 0, 32'h0,  2'b00, 2'b00, 32'h0,  0, 0, 32'h0));
    // Single write from requester 0, zero-wait target.
    vecs.push_back(mk(2'b01, 1, 0, 32'h0,  2'b00, 2'b00, 32'h0,  0, 0, 32'h0));
    vecs.push_back(mk(2'b01, 1, 0, 32'h0,  2'b01, 2'b00, 32'h0,  1, 0, Addr0));
    vecs.push_back(mk(2'b00, 0, 0, 32'h0,  2'b00, 2'b00, 32'h0,  0, 0, 32'h0));
    // Read from requester 1, three wait cycles, then data with error.
    vecs.push_back(mk(2'b10, 0, 0, 32'h0,  2'b00, 2'b00, 32'h0,  0, 0, 32'h0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(2'b10, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 1, 0, Addr1));
    vecs.push_back(mk(2'b10, 1, 1, 32'h1234, 2'b10, 2'b10, 32'h1234, 1, 0, Addr1));
    vecs.push_back(mk(2'b00, 0, 0, 32'h0,  2'b00, 2'b00, 32'h0,  0, 0, 32'h0));
    // Requester 0 against a target that never answers: watchdog on BUSY cycle 8.
    vecs.push_back(mk(2'b01, 0, 0, 32'hFFFF, 2'b00, 2'b00, 32'h0, 0, 0, 32'h0));
    for (int i = 0; i < TO - 1; i++)
      vecs.push_back(mk(2'b01, 0, 0, 32'hFFFF, 2'b00, 2'b00, 32'h0, 1, 0, Addr0));
    vecs.push_back(mk(2'b01, 0, 0, 32'hFFFF, 2'b01, 2'b01, 32'h0, 1, 1, Addr0));
    vecs.push_back(mk(2'b00, 0, 0, 32'h0,  2'b00, 2'b00, 32'h0,  0, 0, 32'h0));

    // Reset state.
    nextCycle();
    nextCycle();
    checkOutput("reset ready", 64'(reqReady), 64'h0);
    checkOutput("reset error", 64'(reqError), 64'h0);
    checkOutput("reset rdata", 64'(reqRdata), 64'h0);
    checkOutput("reset reg_valid", 64'(regValid), 64'h0);
    checkOutput("reset busy", 64'(busy), 64'h0);
    checkOutput("reset timeout", 64'(timeoutPulse), 64'h0);
    checkOutput("reset reg_addr", 64'(regAddr), 64'h0);
    checkOutput("reset reg_wdata", 64'(regWdata), 64'h0);
    checkOutput("reset reg_write", 64'(regWrite), 64'h0);
    checkOutput("reset reg_wstrb", 64'(regWstrb), 64'h0);
    rstN = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Requester 1 (pointer now 1): ready arrives on the watchdog cycle itself,
    // so the normal response must win.
    applyStimulus(mk(2'b10, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 0, 0, 32'h0), "coin idle");
    for (int i = 0; i < TO - 1; i++)
      applyStimulus(mk(2'b10, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 1, 0, Addr1),
                    $sformatf("coin wait%0d", i));
    applyStimulus(mk(2'b10, 1, 0, 32'hA5, 2'b10, 2'b00, 32'hA5, 1, 0, Addr1), "coin hit");
    applyStimulus(mk(2'b00, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 0, 0, 32'h0), "coin after");

    // Move the pointer to 1, then reset while requester 1 is waiting.
    applyStimulus(mk(2'b01, 1, 0, 32'h0, 2'b00, 2'b00, 32'h0, 0, 0, 32'h0), "rst pre idle");
    applyStimulus(mk(2'b01, 1, 0, 32'h0, 2'b01, 2'b00, 32'h0, 1, 0, Addr0), "rst pre busy");
    applyStimulus(mk(2'b10, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 0, 0, 32'h0), "rst req1 idle");
    applyStimulus(mk(2'b10, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 1, 0, Addr1), "rst req1 wait");

    rstN     = 1'b0;
    reqValid = 2'b10;
    regReady = 1'b0;
    #2;
    checkOutput("rst cycle ready", 64'(reqReady), 64'h0);
    nextCycle();
    rstN = 1'b1;
    v = mk(2'b11, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 0, 0, 32'h0);
    applyStimulus(v, "post rst idle");
    v = mk(2'b11, 1, 0, 32'h0, 2'b01, 2'b00, 32'h0, 1, 0, Addr0);
    applyStimulus(v, "post rst grant0");
    applyStimulus(mk(2'b00, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 0, 0, 32'h0), "end idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
